// File: rtl/branch_pred_pkg.sv
// Types and widths shared by the branch predictor, its trainer, the GHR logic
// and the in-flight branch queue.
package branch_pred_pkg;

    localparam int PC_W  = 32;
    localparam int GHR_W = 8;

    typedef struct packed {
        logic [PC_W-1:0]  pc;
        logic             pred;
        logic [GHR_W-1:0] ghr;
    } biq_entry_t;

endpackage

// File: rtl/biq_storage.sv
// Entry array for the in-flight branch queue: one write port at the tail and
// one asynchronous read port at the head. The data itself is never reset.
module biq_storage
    import branch_pred_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_idx,
    input  biq_entry_t               wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_idx,
    output biq_entry_t               rd_data
);

    biq_entry_t mem_q [DEPTH];
    biq_entry_t mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[wr_idx] = wr_data;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rd_data = mem_q[rd_idx];

endmodule

// File: rtl/branch_inflight_queue.sv
// In-order queue of predicted branches awaiting resolution; emits one training
// record per resolved branch. Optional counters enabled with BIQ_STATS_EN.
module branch_inflight_queue
    import branch_pred_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enq_valid,
    output logic                     enq_ready,
    input  logic [PC_W-1:0]          enq_pc,
    input  logic                     enq_pred,
    input  logic [GHR_W-1:0]         enq_ghr,
    input  logic                     res_valid,
    input  logic [PC_W-1:0]          res_pc,
    input  logic                     res_taken,
    input  logic                     flush,
    output logic                     train_valid,
    output logic [PC_W-1:0]          train_pc,
    output logic                     train_taken,
    output logic                     train_pred,
    output logic [GHR_W-1:0]         train_ghr,
    output logic                     mispredict,
    output logic                     orphan_err,
    output logic [$clog2(DEPTH):0]   count,
    output logic [31:0]              stat_resolved,
    output logic [31:0]              stat_mispred
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d, head_next;
    logic             full, empty;
    logic             res_hit, res_miss, squash, enq_fire;
    biq_entry_t       head_entry, enq_entry;

    logic             train_valid_q, train_valid_d;
    logic [PC_W-1:0]  train_pc_q, train_pc_d;
    logic             train_taken_q, train_taken_d;
    logic             train_pred_q, train_pred_d;
    logic [GHR_W-1:0] train_ghr_q, train_ghr_d;
    logic             mispredict_q, mispredict_d;
    logic             orphan_q, orphan_d;

    assign empty     = (head_q == tail_q);
    assign full      = (head_q[PTR_W-1] != tail_q[PTR_W-1]) &&
                       (head_q[IDX_W-1:0] == tail_q[IDX_W-1:0]);
    assign enq_ready = !full;
    assign count     = tail_q - head_q;
    assign head_next = head_q + PTR_W'(1);

    assign enq_entry = '{pc: enq_pc, pred: enq_pred, ghr: enq_ghr};

    biq_storage #(.DEPTH(DEPTH)) u_storage (
        .clk     (clk),
        .wr_en   (enq_fire),
        .wr_idx  (tail_q[IDX_W-1:0]),
        .wr_data (enq_entry),
        .rd_idx  (head_q[IDX_W-1:0]),
        .rd_data (head_entry)
    );

    // A mispredicted pop means everything younger is wrong-path, including a
    // branch arriving from decode in the same cycle.
    assign res_hit  = res_valid && !empty && (head_entry.pc == res_pc);
    assign res_miss = res_valid && !res_hit;
    assign squash   = res_hit && (head_entry.pred != res_taken);
    assign enq_fire = enq_valid && enq_ready && !flush && !squash;

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        if (res_valid && !empty) begin
            head_d = head_next;
        end
        if (squash) begin
            tail_d = head_next;
        end else if (enq_fire) begin
            tail_d = tail_q + PTR_W'(1);
        end
        if (flush) begin
            head_d = '0;
            tail_d = '0;
        end
    end

    always_comb begin
        train_valid_d = res_hit;
        mispredict_d  = squash;
        train_pc_d    = train_pc_q;
        train_taken_d = train_taken_q;
        train_pred_d  = train_pred_q;
        train_ghr_d   = train_ghr_q;
        if (res_hit) begin
            train_pc_d    = head_entry.pc;
            train_taken_d = res_taken;
            train_pred_d  = head_entry.pred;
            train_ghr_d   = head_entry.ghr;
        end
        orphan_d = orphan_q || res_miss;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q        <= '0;
            tail_q        <= '0;
            train_valid_q <= 1'b0;
            train_pc_q    <= '0;
            train_taken_q <= 1'b0;
            train_pred_q  <= 1'b0;
            train_ghr_q   <= '0;
            mispredict_q  <= 1'b0;
            orphan_q      <= 1'b0;
        end else begin
            head_q        <= head_d;
            tail_q        <= tail_d;
            train_valid_q <= train_valid_d;
            train_pc_q    <= train_pc_d;
            train_taken_q <= train_taken_d;
            train_pred_q  <= train_pred_d;
            train_ghr_q   <= train_ghr_d;
            mispredict_q  <= mispredict_d;
            orphan_q      <= orphan_d;
        end
    end

    assign train_valid = train_valid_q;
    assign train_pc    = train_pc_q;
    assign train_taken = train_taken_q;
    assign train_pred  = train_pred_q;
    assign train_ghr   = train_ghr_q;
    assign mispredict  = mispredict_q;
    assign orphan_err  = orphan_q;

`ifdef BIQ_STATS_EN
    logic [31:0] stat_resolved_q, stat_resolved_d;
    logic [31:0] stat_mispred_q, stat_mispred_d;

    // Counters advance on the same edge that raises train_valid/mispredict.
    always_comb begin
        stat_resolved_d = stat_resolved_q;
        stat_mispred_d  = stat_mispred_q;
        if (res_hit && (stat_resolved_q != 32'hFFFF_FFFF)) begin
            stat_resolved_d = stat_resolved_q + 32'd1;
        end
        if (squash && (stat_mispred_q != 32'hFFFF_FFFF)) begin
            stat_mispred_d = stat_mispred_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_resolved_q <= '0;
            stat_mispred_q  <= '0;
        end else begin
            stat_resolved_q <= stat_resolved_d;
            stat_mispred_q  <= stat_mispred_d;
        end
    end

    assign stat_resolved = stat_resolved_q;
    assign stat_mispred  = stat_mispred_q;
`else
    assign stat_resolved = 32'd0;
    assign stat_mispred  = 32'd0;
`endif

endmodule

// File: tb/tb_branch_inflight_queue.sv
// Scoreboard bench for branch_inflight_queue: directed stimulus pushes expected
// training records; a negedge monitor pops and compares them.
module tb_branch_inflight_queue;

    logic        clk;
    logic        rst;
    logic        enq_valid;
    logic        enq_ready;
    logic [31:0] enq_pc;
    logic        enq_pred;
    logic [7:0]  enq_ghr;
    logic        res_valid;
    logic [31:0] res_pc;
    logic        res_taken;
    logic        flush;
    logic        train_valid;
    logic [31:0] train_pc;
    logic        train_taken;
    logic        train_pred;
    logic [7:0]  train_ghr;
    logic        mispredict;
    logic        orphan_err;
    logic [2:0]  count;
    logic [31:0] stat_resolved;
    logic [31:0] stat_mispred;

    typedef struct {
        logic [31:0] pc;
        logic        taken;
        logic        pred;
        logic [7:0]  ghr;
        logic        mis;
    } exp_t;

    exp_t sbQ[$];
    exp_t monE;
    int   total = 0;
    int   bad = 0;
    int   expResolved = 0;
    int   expMispred = 0;

    branch_inflight_queue #(.DEPTH(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .enq_valid     (enq_valid),
        .enq_ready     (enq_ready),
        .enq_pc        (enq_pc),
        .enq_pred      (enq_pred),
        .enq_ghr       (enq_ghr),
        .res_valid     (res_valid),
        .res_pc        (res_pc),
        .res_taken     (res_taken),
        .flush         (flush),
        .train_valid   (train_valid),
        .train_pc      (train_pc),
        .train_taken   (train_taken),
        .train_pred    (train_pred),
        .train_ghr     (train_ghr),
        .mispredict    (mispredict),
        .orphan_err    (orphan_err),
        .count         (count),
        .stat_resolved (stat_resolved),
        .stat_mispred  (stat_mispred)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h want=%0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs; returns #1 after the sampling edge.
    task automatic applyStimulus(input logic ev, input logic [31:0] epc, input logic ep,
                                 input logic [7:0] eg, input logic rv, input logic [31:0] rpc,
                                 input logic rt, input logic fl);
        enq_valid = ev;
        enq_pc    = epc;
        enq_pred  = ep;
        enq_ghr   = eg;
        res_valid = rv;
        res_pc    = rpc;
        res_taken = rt;
        flush     = fl;
        @(posedge clk);
        #1;
        enq_valid = 1'b0;
        res_valid = 1'b0;
        flush     = 1'b0;
    endtask

    task automatic enq(input logic [31:0] pc, input logic pred, input logic [7:0] ghr);
        applyStimulus(1'b1, pc, pred, ghr, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic res(input logic [31:0] pc, input logic taken);
        applyStimulus(1'b0, 32'h0, 1'b0, 8'h0, 1'b1, pc, taken, 1'b0);
    endtask

    task automatic expectTrain(input logic [31:0] pc, input logic taken, input logic pred,
                               input logic [7:0] ghr);
        exp_t e;
        e.pc    = pc;
        e.taken = taken;
        e.pred  = pred;
        e.ghr   = ghr;
        e.mis   = (pred != taken);
        sbQ.push_back(e);
        expResolved++;
        if (e.mis) expMispred++;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (train_valid) begin
                if (sbQ.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected_train: got pc=%0h want=no record", train_pc);
                end else begin
                    monE = sbQ.pop_front();
                    checkOutput("train_pc", train_pc, monE.pc);
                    checkOutput("train_taken", {31'b0, train_taken}, {31'b0, monE.taken});
                    checkOutput("train_pred", {31'b0, train_pred}, {31'b0, monE.pred});
                    checkOutput("train_ghr", {24'b0, train_ghr}, {24'b0, monE.ghr});
                    checkOutput("mispredict", {31'b0, mispredict}, {31'b0, monE.mis});
                end
            end else begin
                checkOutput("mispredict_idle", {31'b0, mispredict}, 32'd0);
            end
        end
    end

    initial begin
        rst = 1'b1;
        enq_valid = 1'b0; enq_pc = '0; enq_pred = 1'b0; enq_ghr = '0;
        res_valid = 1'b0; res_pc = '0; res_taken = 1'b0; flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        checkOutput("rst_count", {29'b0, count}, 32'd0);
        checkOutput("rst_enq_ready", {31'b0, enq_ready}, 32'd1);
        checkOutput("rst_train_valid", {31'b0, train_valid}, 32'd0);
        checkOutput("rst_train_pc", train_pc, 32'd0);
        checkOutput("rst_orphan", {31'b0, orphan_err}, 32'd0);
        checkOutput("rst_stat_resolved", stat_resolved, 32'd0);
        checkOutput("rst_stat_mispred", stat_mispred, 32'd0);

        $display("[TB] basic enqueue/resolve");
        enq(32'h100, 1'b1, 8'h5A);
        checkOutput("t1_count_after_enq", {29'b0, count}, 32'd1);
        expectTrain(32'h100, 1'b1, 1'b1, 8'h5A);
        res(32'h100, 1'b1);
        checkOutput("t1_train_valid", {31'b0, train_valid}, 32'd1);
        checkOutput("t1_count", {29'b0, count}, 32'd0);

        $display("[TB] full queue and wrap");
        for (int i = 0; i < 4; i++) enq(32'h10 + 32'(4 * i), 1'b0, 8'(i + 1));
        checkOutput("t2_count_full", {29'b0, count}, 32'd4);
        checkOutput("t2_enq_ready_full", {31'b0, enq_ready}, 32'd0);
        enq(32'h20, 1'b1, 8'hEE);
        checkOutput("t2_count_ignored", {29'b0, count}, 32'd4);
        expectTrain(32'h10, 1'b0, 1'b0, 8'h01);
        applyStimulus(1'b1, 32'h24, 1'b1, 8'hEF, 1'b1, 32'h10, 1'b0, 1'b0);
        checkOutput("t2_count_after_pop", {29'b0, count}, 32'd3);
        checkOutput("t2_enq_ready_after_pop", {31'b0, enq_ready}, 32'd1);
        expectTrain(32'h14, 1'b0, 1'b0, 8'h02);
        res(32'h14, 1'b0);
        expectTrain(32'h18, 1'b0, 1'b0, 8'h03);
        res(32'h18, 1'b0);
        expectTrain(32'h1C, 1'b1, 1'b0, 8'h04);
        res(32'h1C, 1'b1);
        checkOutput("t2_count_drained", {29'b0, count}, 32'd0);

        $display("[TB] mispredict squash");
        enq(32'h100, 1'b0, 8'h11);
        enq(32'h104, 1'b1, 8'h12);
        enq(32'h108, 1'b1, 8'h13);
        checkOutput("t3_count_3", {29'b0, count}, 32'd3);
        expectTrain(32'h100, 1'b1, 1'b0, 8'h11);
        applyStimulus(1'b1, 32'h10C, 1'b1, 8'h14, 1'b1, 32'h100, 1'b1, 1'b0);
        checkOutput("t3_count_squashed", {29'b0, count}, 32'd0);
        checkOutput("t3_orphan_clear", {31'b0, orphan_err}, 32'd0);
        enq(32'h300, 1'b1, 8'h33);
        expectTrain(32'h300, 1'b0, 1'b1, 8'h33);
        res(32'h300, 1'b0);
        checkOutput("t3_orphan_still_clear", {31'b0, orphan_err}, 32'd0);

        $display("[TB] orphan resolves");
        res(32'h400, 1'b1);
        checkOutput("t4_orphan_empty", {31'b0, orphan_err}, 32'd1);
        checkOutput("t4_count_empty", {29'b0, count}, 32'd0);
        applyStimulus(1'b0, 32'h0, 1'b0, 8'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("t4_orphan_sticky", {31'b0, orphan_err}, 32'd1);
        enq(32'h200, 1'b1, 8'h21);
        enq(32'h208, 1'b1, 8'h22);
        res(32'h204, 1'b1);
        checkOutput("t4_count_discard", {29'b0, count}, 32'd1);
        expectTrain(32'h208, 1'b1, 1'b1, 8'h22);
        res(32'h208, 1'b1);
        checkOutput("t4_count_after", {29'b0, count}, 32'd0);
        applyStimulus(1'b1, 32'h500, 1'b0, 8'h50, 1'b1, 32'h500, 1'b0, 1'b0);
        checkOutput("t4_res_on_first_enq", {29'b0, count}, 32'd1);
        expectTrain(32'h500, 1'b0, 1'b0, 8'h50);
        res(32'h500, 1'b0);
        checkOutput("t4_orphan_final", {31'b0, orphan_err}, 32'd1);

        $display("[TB] flush with enqueue and resolve");
        enq(32'h600, 1'b1, 8'h61);
        enq(32'h604, 1'b0, 8'h62);
        expectTrain(32'h600, 1'b1, 1'b1, 8'h61);
        applyStimulus(1'b1, 32'h608, 1'b1, 8'h63, 1'b1, 32'h600, 1'b1, 1'b1);
        checkOutput("t5_count_flushed", {29'b0, count}, 32'd0);
        enq(32'h700, 1'b1, 8'h71);
        checkOutput("t5_count_post", {29'b0, count}, 32'd1);
        expectTrain(32'h700, 1'b1, 1'b1, 8'h71);
        res(32'h700, 1'b1);

        repeat (3) @(posedge clk);
        #1;
        checkOutput("sb_drained", 32'(sbQ.size()), 32'd0);
`ifdef BIQ_STATS_EN
        checkOutput("stat_resolved", stat_resolved, 32'(expResolved));
        checkOutput("stat_mispred", stat_mispred, 32'(expMispred));
`else
        checkOutput("stat_resolved_off", stat_resolved, 32'd0);
        checkOutput("stat_mispred_off", stat_mispred, 32'd0);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
